prewish5k_controller: RTL and testbench
=======================================

Name: prewish5k_controller

Overview:
- Top-level controller of the prewish5k blinky design.
- A debounced push-button press captures an 8-bit pattern from an active-low DIP switch.
- The pattern is handed to a blinker at the next "new-mask" frame boundary.
- The blinker drives one LED serially, bit by bit, from the pattern; four status LEDs expose internal state.

Parameters:
- NEWMASK_CLK_BITS, 26, width of the free-running frame counter; a new-mask tick occurs every 2^NEWMASK_CLK_BITS cycles.
- BLINKY_MASK_CLK_BITS, 19, width of the blinker prescaler; each pattern bit is shown for 2^BLINKY_MASK_CLK_BITS cycles. Must be < NEWMASK_CLK_BITS.
- DEBOUNCE_BITS, 5, the button must be stable for 2^DEBOUNCE_BITS consecutive cycles before its debounced state changes.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- button_internal  in  1  raw button, active high (asynchronous, bouncy).
- dip_switch  in  8  user pattern, active low (switch on = 0 = mask bit 1).
- the_led  out  1  blinker output, active high.
- o_led0  out  1  debounced button state.
- o_led1  out  1  pending-mask-valid flag.
- o_led2  out  1  toggles on every accepted press.
- o_led3  out  1  frame heartbeat = MSB of the frame counter.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) clears the following:
  - synchronizer, debounce counter, debounced state;
  - frame counter, prescaler;
  - pending_mask=0, pending_valid=0, active_mask=0, bit index=7.
  - Consequently all outputs are 0.
- Synchronizer: 2-flop on button_internal, giving btn_s.
- Debouncer:
  - Counter clears whenever btn_s equals the debounced state.
  - Otherwise it increments.
  - When the counter reaches 2^DEBOUNCE_BITS-1 while still different, the debounced state flips and the counter clears.
  - Pulses shorter than 2^DEBOUNCE_BITS cycles are ignored.
- Accepted press:
  - Defined as a 0→1 edge of the debounced state (one-cycle pulse).
  - On it: pending_mask <= ~dip_switch (sampled that cycle), pending_valid <= 1, o_led2 toggles.
  - A second accepted press before the tick overwrites pending_mask.
- Frame counter:
  - Free-running NEWMASK_CLK_BITS-bit counter.
  - tick = counter all-ones; the counter wraps to 0.
- On tick with pending_valid=1:
  - active_mask <= pending_mask;
  - index <= 7;
  - prescaler <= 0;
  - pending_valid <= 0.
  - Pattern restarts MSB-first on the next cycle.
- On tick with pending_valid=0: nothing changes; the blinker free-runs.
- Press and tick in the same cycle: the freshly sampled ~dip_switch goes straight to active_mask, and pending_valid ends 0.
- Blinker:
  - BLINKY_MASK_CLK_BITS prescaler; on prescaler wrap the index decrements.
  - Index wraps 0→7.
  - the_led = active_mask[index], registered (1-cycle latency after an index change).
- Mask 0x00 keeps the LED dark; 0xFF keeps it lit.
- Reset mid-operation discards any pending pattern and any press in progress.

Optional Feature:
- Macro PREWISH5K_STATUS_LEDS_EN.
- Defined: o_led0..o_led3 are driven as specified above.
- Undefined: o_led0..o_led3 are tied to 0 and their status logic is not built. the_led is unaffected.

Test Plan:
Bench settings: NEWMASK_CLK_BITS=16, BLINKY_MASK_CLK_BITS=9, DEBOUNCE_BITS=5.
- Reset: hold i_rst_n=0 for 4 cycles → all outputs 0; after release, the_led stays 0 for a full 65536-cycle frame with no press.
- Valid press:
  - Stimulus: dip_switch=0101_1111, button high for 50 cycles.
  - Response: o_led0 rises 34 cycles after the input edge (2 sync + 32 debounce); o_led1=1; o_led2=1.
  - At the next tick, o_led1=0 and active_mask=1010_0000.
  - the_led shows high 512 cycles, low 512, high 512, low 2560, repeating.
- Glitch rejection:
  - Stimulus: button high for 9 cycles after the first press has been released and debounced.
  - Response: o_led0, o_led1 and o_led2 unchanged; pattern unchanged.
- Second valid press:
  - Stimulus: dip_switch=0011_0011, button high 37 cycles.
  - Response: o_led2 toggles back to 0.
  - After the next tick, mask=1100_1100: the_led high 1024, low 1024, repeating.
- Coincident press and tick: align the debounced edge with the tick cycle → active_mask takes the new value immediately; o_led1 remains 0.
- Reset mid-pending: press accepted, then i_rst_n=0 before the tick → after reset o_led1=0, active_mask=0, the_led=0.

Source files
------------

// File: rtl/prewish5k_controller.sv
// Blinky top: a debounced press captures a DIP pattern, which is loaded at the next frame tick and shown serially on the_led.
// Optional status LEDs are built only when PREWISH5K_STATUS_LEDS_EN is defined; otherwise o_led0..o_led3 read 0.
module prewish5k_controller #(
   parameter int NEWMASK_CLK_BITS     = 26,
   parameter int BLINKY_MASK_CLK_BITS = 19,
   parameter int DEBOUNCE_BITS        = 5
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       button_internal,
   input  logic [7:0] dip_switch,
   output logic       the_led,
   output logic       o_led0,
   output logic       o_led1,
   output logic       o_led2,
   output logic       o_led3
);

   logic                            btn_meta;
   logic                            btn_s;
   logic [DEBOUNCE_BITS-1:0]        db_cnt;
   logic                            db_state;
   logic [NEWMASK_CLK_BITS-1:0]     frame_cnt;
   logic [BLINKY_MASK_CLK_BITS-1:0] prescaler;
   logic [7:0]                      pending_mask;
   logic [7:0]                      active_mask;
   logic                            pending_valid;
   logic [2:0]                      bit_idx;
   logic                            press;
   logic                            tick;

   // The press pulse fires in the same cycle the debounced state is about to rise.
   assign press = (btn_s != db_state) && (&db_cnt) && btn_s;
   assign tick  = &frame_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         btn_meta      <= 1'b0;
         btn_s         <= 1'b0;
         db_cnt        <= '0;
         db_state      <= 1'b0;
         frame_cnt     <= '0;
         prescaler     <= '0;
         pending_mask  <= 8'h00;
         pending_valid <= 1'b0;
         active_mask   <= 8'h00;
         bit_idx       <= 3'd7;
         the_led       <= 1'b0;
      end else begin
         btn_meta <= button_internal;
         btn_s    <= btn_meta;

         if (btn_s == db_state) begin
            db_cnt <= '0;
         end else if (&db_cnt) begin
            db_cnt   <= '0;
            db_state <= btn_s;
         end else begin
            db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
         end

         frame_cnt <= frame_cnt + NEWMASK_CLK_BITS'(1);

         // A press coinciding with the tick bypasses the pending register.
         if (tick && (pending_valid || press)) begin
            active_mask   <= press ? ~dip_switch : pending_mask;
            bit_idx       <= 3'd7;
            prescaler     <= '0;
            pending_valid <= 1'b0;
         end else begin
            if (press) begin
               pending_mask  <= ~dip_switch;
               pending_valid <= 1'b1;
            end
            prescaler <= prescaler + BLINKY_MASK_CLK_BITS'(1);
            if (&prescaler)
               bit_idx <= bit_idx - 3'd1;
         end

         the_led <= active_mask[bit_idx];
      end
   end

`ifdef PREWISH5K_STATUS_LEDS_EN
   logic press_toggle;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         press_toggle <= 1'b0;
      else if (press)
         press_toggle <= ~press_toggle;
   end

   assign o_led0 = db_state;
   assign o_led1 = pending_valid;
   assign o_led2 = press_toggle;
   assign o_led3 = frame_cnt[NEWMASK_CLK_BITS-1];
`else
   assign o_led0 = 1'b0;
   assign o_led1 = 1'b0;
   assign o_led2 = 1'b0;
   assign o_led3 = 1'b0;
`endif

endmodule

// File: tb/tb_prewish5k_controller.sv
// Scoreboard bench for prewish5k_controller: stimulus schedules expected output values per cycle, a negedge monitor checks them.
// The frame counter is shortened to 13 bits so the run stays short; debounce and blink slot widths are unchanged.
module tb_prewish5k_controller;

   localparam int NB   = 13;
   localparam int BB   = 9;
   localparam int DB   = 5;
   localparam int FR   = 1 << NB;
   localparam int SLOT = 1 << BB;
`ifdef PREWISH5K_STATUS_LEDS_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       button = 1'b0;
   logic [7:0] dip = 8'hFF;
   logic       the_led, o_led0, o_led1, o_led2, o_led3;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int    at;
      int    sig;
      logic  exp;
      string name;
   } chk_t;

   chk_t sb[$];

   prewish5k_controller #(
      .NEWMASK_CLK_BITS    (NB),
      .BLINKY_MASK_CLK_BITS(BB),
      .DEBOUNCE_BITS       (DB)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .button_internal(button),
      .dip_switch     (dip),
      .the_led        (the_led),
      .o_led0         (o_led0),
      .o_led1         (o_led1),
      .o_led2         (o_led2),
      .o_led3         (o_led3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // sig: 0=the_led, 1..4=o_led0..o_led3
   task automatic expect_at(input int at, input int sig, input logic exp, input string name);
      chk_t e;
      int   i;
      e.at = at; e.sig = sig; e.exp = exp; e.name = name;
      i = sb.size();
      while (i > 0 && sb[i-1].at > at) i--;
      sb.insert(i, e);
   endtask

   task automatic expect_stat(input int at, input int sig, input logic exp, input string name);
      expect_at(at, sig, exp & STAT, name);
   endtask

   function automatic logic led_bit(input logic [7:0] m, input int t, input int c);
      int j;
      j = ((c - t - 1) / SLOT) % 8;
      return m[7-j];
   endfunction

   task automatic sched_pattern(input logic [7:0] m, input int t, input int slots, input string name);
      for (int j = 0; j < slots; j++) begin
         int c;
         c = t + 1 + j * SLOT;
         expect_at(c, 0, led_bit(m, t, c), name);
         expect_at(c + SLOT/2, 0, led_bit(m, t, c + SLOT/2), name);
         expect_at(c + SLOT - 1, 0, led_bit(m, t, c + SLOT - 1), name);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk) begin
      logic [4:0] outs;
      chk_t       e;
      outs = {o_led3, o_led2, o_led1, o_led0, the_led};
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (e.at < cyc) begin
            errors++;
            $display("FAIL %s: check for cycle %0d not reached in time (now %0d)", e.name, e.at, cyc);
         end else if (outs[e.sig] !== e.exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: output %0d is %b, required %b", e.name, cyc, e.sig, outs[e.sig], e.exp);
         end
      end
   end

   initial begin
      int r, e1, t1, e2, t2, e3, t3, e4, r2;
      r  = 4;
      e1 = r + FR + 500;
      t1 = r + 2*FR;
      e2 = t1 + 300;
      t2 = r + 3*FR;
      t3 = r + 4*FR;
      e3 = t3 - 34;
      e4 = t3 + 5000;
      r2 = e4 + 104;

      // reset and an idle frame
      for (int s = 0; s < 5; s++) expect_at(r, s, 1'b0, "reset_outputs");
      expect_at  (r + FR/2 - 1, 4, 1'b0, "heartbeat_low");
      expect_stat(r + FR/2,     4, 1'b1, "heartbeat_high");
      expect_stat(r + FR - 1,   4, 1'b1, "heartbeat_end");
      expect_at  (r + FR,       4, 1'b0, "heartbeat_wrap");
      for (int k = 1; k <= 8; k++) expect_at(r + k*(FR/8) - 3, 0, 1'b0, "dark_frame");
      expect_at(r + FR + 5, 0, 1'b0, "dark_after_tick");

      // first press, then a glitch
      expect_at  (e1 + 33, 1, 1'b0, "debounce_not_yet");
      expect_stat(e1 + 34, 1, 1'b1, "debounce_rise");
      expect_stat(e1 + 34, 2, 1'b1, "pending_set");
      expect_stat(e1 + 34, 3, 1'b1, "toggle_first");
      expect_stat(e1 + 83, 1, 1'b1, "release_not_yet");
      expect_at  (e1 + 84, 1, 1'b0, "release_fall");
      expect_at  (e1 + 205, 1, 1'b0, "glitch_db_mid");
      expect_at  (e1 + 260, 1, 1'b0, "glitch_db_after");
      expect_stat(e1 + 260, 2, 1'b1, "glitch_pending_kept");
      expect_stat(e1 + 260, 3, 1'b1, "glitch_toggle_kept");
      expect_stat(t1,       2, 1'b1, "pending_before_tick");
      expect_at  (t1 + 1,   2, 1'b0, "pending_cleared_tick");
      expect_at  (t1,       0, 1'b0, "led_before_load");
      sched_pattern(8'hA0, t1, 16, "pattern_a0");

      // second press
      expect_stat(e2 + 33, 3, 1'b1, "toggle_before_second");
      expect_at  (e2 + 34, 3, 1'b0, "toggle_second");
      expect_stat(e2 + 34, 2, 1'b1, "pending_second");
      sched_pattern(8'hCC, t2, 16, "pattern_cc");

      // press coinciding with the tick
      expect_at  (t3,     2, 1'b0, "coincident_pending");
      expect_at  (t3 + 1, 2, 1'b0, "coincident_pending_after");
      expect_stat(t3,     3, 1'b1, "coincident_toggle");
      expect_stat(t3,     1, 1'b1, "coincident_db");
      sched_pattern(8'h0F, t3, 8, "pattern_0f");

      // press then reset before the tick
      expect_stat(e4 + 34, 2, 1'b1, "pending_before_reset");
      for (int s = 0; s < 5; s++) expect_at(r2, s, 1'b0, "midreset_outputs");
      for (int k = 1; k <= 9; k++) expect_at(r2 + k*(FR/8) - 5, 0, 1'b0, "midreset_dark");
      expect_at(r2 + FR + 10, 2, 1'b0, "midreset_no_pending");

      wait_cyc(r);
      rst_n = 1'b1;

      wait_cyc(e1);
      dip = 8'b0101_1111;
      button = 1'b1;
      wait_cyc(e1 + 50);
      button = 1'b0;
      wait_cyc(e1 + 200);
      dip = 8'h00;
      button = 1'b1;
      wait_cyc(e1 + 209);
      button = 1'b0;

      wait_cyc(e2);
      dip = 8'b0011_0011;
      button = 1'b1;
      wait_cyc(e2 + 37);
      button = 1'b0;

      wait_cyc(e3);
      dip = 8'hF0;
      button = 1'b1;
      wait_cyc(e3 + 40);
      button = 1'b0;

      wait_cyc(e4);
      dip = 8'h00;
      button = 1'b1;
      wait_cyc(e4 + 40);
      button = 1'b0;
      wait_cyc(e4 + 100);
      rst_n = 1'b0;
      wait_cyc(r2);
      rst_n = 1'b1;

      wait_cyc(r2 + FR + FR/8 + 20);
      while (sb.size() > 0) begin
         chk_t e;
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: check for cycle %0d never evaluated", e.name, e.at);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
